// File: rtl/cpu_defs.sv
// cpu_defs: CPU-wide widths shared with the data memory, plus the dump FSM state encoding
package cpu_defs;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int DMEM_DEPTH = 512;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAPT, S_EMIT, S_DONE} dump_state_e;
endpackage

// File: rtl/mem_dump_unit_if.sv
// mem_dump_unit_if: data-memory read port plus the dumped-word valid/ready stream
interface mem_dump_unit_if #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  modport master (
    output mem_rd_en, mem_addr, out_valid, out_data, out_addr,
    input  mem_rdata, out_ready
  );
  modport slave (
    input  mem_rd_en, mem_addr, out_valid, out_data, out_addr,
    output mem_rdata, out_ready
  );
endinterface

// File: rtl/mem_dump_unit_rise_detect.sv
// rise_detect: registered rising-edge detector for CPU status lines
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_q;
  // Previous level; cleared on reset so a line held high through reset still fires once
  always_ff @(posedge clk) d_q <= rst ? 1'b0 : d;
  assign pulse = d & ~d_q;
endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: post-halt data-memory dumper with a valid/ready word stream and checksum
module mem_dump_unit
  import cpu_defs::*;
#(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int ADDR_W = cpu_defs::ADDR_W,
  parameter int DEPTH  = cpu_defs::DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_display,
  mem_dump_unit_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] checksum_q;
  logic              start;
  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (is_display),
    .pulse(start)
  );
  // Sequencer: fetch a word, capture it, hold it until accepted, then advance or finish
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_REQ;
          addr_q     <= '0;
          checksum_q <= '0;
        end
        S_REQ: state_q <= S_CAPT;
        S_CAPT: begin
          out_data_q <= bus.mem_rdata;
          out_addr_q <= addr_q;
          state_q    <= S_EMIT;
        end
        S_EMIT: if (bus.out_ready) begin
          checksum_q <= checksum_q + out_data_q;
          if (addr_q == LAST) state_q <= S_DONE;
          else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_REQ;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.mem_rd_en = state_q == S_REQ;
  assign bus.mem_addr  = addr_q;
  assign bus.out_valid = state_q == S_EMIT;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign busy          = state_q == S_REQ || state_q == S_CAPT || state_q == S_EMIT;
  assign done          = state_q == S_DONE;
  assign checksum      = checksum_q;
endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Post-halt data-memory reader for the CPU: when the CPU raises `is_display` at program end, this block reads every word of data memory in order through the memory's synchronous read port. It presents each word on a valid/ready output stream for the testbench or display logic, and reports completion with a running checksum. It sits beside `CPU` at top level and consumes `is_display`, which the CPU drives when it stops.

## Interface
Parameters:
- `DATA_W`, 32, memory word width
- `ADDR_W`, 9, word-address width
- `DEPTH`, 512, words dumped; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `is_display`  in  1  CPU halt/display request; level signal, the rising edge starts a dump
- `mem_rd_en`  out  1  read strobe to data memory
- `mem_addr`  out  ADDR_W  word address to data memory
- `mem_rdata`  in  DATA_W  read data, valid exactly one cycle after the `mem_rd_en` cycle
- `out_valid`  out  1  `out_data`/`out_addr` hold a word
- `out_ready`  in  1  consumer accepts the word
- `out_data`  out  DATA_W  dumped word
- `out_addr`  out  ADDR_W  address of `out_data`
- `busy`  out  1  dump in progress
- `done`  out  1  one-cycle pulse after the last word is accepted
- `checksum`  out  DATA_W  sum mod 2^DATA_W of all words accepted in the current or last dump

## Operation
- Rising-edge detect: `start = is_display & ~disp_q`, with `disp_q` registered each cycle. `disp_q` resets to 0, so `is_display` held high across reset starts a dump in the first cycle after reset.
- States and transitions:
  - IDLE: on `start`, go to REQ with addr=0 and checksum cleared; otherwise stay in IDLE.
  - REQ: `mem_rd_en`=1, `mem_addr`=addr. Next state is CAPT.
  - CAPT: register `mem_rdata` into `out_data` and addr into `out_addr`. Next state is EMIT.
  - EMIT: `out_valid`=1. On `out_valid & out_ready`, add the word to `checksum`.
    - If addr==DEPTH-1, go to DONE.
    - Otherwise increment addr and go to REQ.
    - With no handshake, stay in EMIT with data held stable.
  - DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in REQ, CAPT and EMIT.
- `mem_rd_en`, `out_valid`, `busy` and `done` are decoded from the registered state only, with no combinational path from inputs.
- `start` is ignored outside IDLE; re-raising `is_display` mid-dump has no effect.
- Arithmetic:
  - addr is ADDR_W bits and never wraps; the terminal compare is against DEPTH-1.
  - `checksum` is a DATA_W-bit adder with the carry discarded.
  - `checksum` stays valid and stable after DONE until the next `start`.
- `mem_addr` outside REQ: it holds the current addr; `mem_rd_en`=0 makes its value don't-care.

## Timing
- Reset values: state IDLE; `mem_rd_en`, `out_valid`, `busy`, `done` = 0; `mem_addr`, `out_addr`, `out_data`, `checksum` = 0.
- `rst` mid-dump forces the reset state on the next edge and drops the stream without a `done` pulse.
- `start` at edge k produces:
  - REQ for word 0 in cycle k+1
  - `mem_rdata` valid in k+2
  - `out_valid` first high in k+3
- Per-word cost is 3 cycles when `out_ready` is held high. A full dump with `out_ready`=1 takes 3·DEPTH+1 cycles from the first REQ through the DONE cycle.
- `out_ready` may be high before `out_valid`. A handshake occurs only in a cycle where both are high.
- `out_valid` never drops without a handshake, except on `rst`.

## Structure
- Shared package/header `cpu_defs`: `DATA_W`, `ADDR_W`, `DMEM_DEPTH` constants, reused by the CPU data memory; the dump FSM state encoding (IDLE, REQ, CAPT, EMIT, DONE) as localparams/enum.
- One sub-module, `rise_detect`: the registered edge detector (in `clk`, `rst`, `d`; out `pulse`), reusable for other CPU status lines.
- The remainder (FSM, address counter, output register, checksum accumulator) stays flat in `mem_dump_unit`.

## Test plan
- Basic dump, DEPTH=4, memory preloaded {0x11, 0x22, 0x33, 0x44}, `out_ready`=1, `is_display` rises at cycle 10:
  - `mem_rd_en` high at cycles 11, 14, 17, 20
  - words 0x11..0x44 delivered at addr 0..3
  - `done` pulses at cycle 23
  - `checksum`=0xAA
- Backpressure: same setup with `out_ready` low for 5 cycles while word 1 is presented. `out_valid`, `out_data`=0x22 and `out_addr`=1 must stay stable. No extra `mem_rd_en` is issued. Order and checksum are unchanged.
- Overflow and retrigger:
  - Words {0xFFFFFFFF, 0x00000002}: `checksum`=0x00000001.
  - Toggle `is_display` low then high mid-dump: no restart, exactly 2 words delivered.
  - After `done`, a new rising edge dumps again and the checksum restarts from 0.
- Reset mid-operation: assert `rst` for 1 cycle during EMIT of word 2. Next cycle shows all outputs 0 and state IDLE, with no `done` pulse. `is_display` still high produces a fresh dump starting at addr 0.
- Full depth: DEPTH=512, memory[i]=i, random `out_ready`:
  - all 512 words delivered in order exactly once
  - `checksum`=130816 (0x1FF00)
  - `busy` drops in the same cycle `done` rises
